// File: rtl/axi_wr_arb.sv
// -----------------------------------------------------------------------------
// axi_wr_arb
// Shares the single LSU-side AXI write port between NREQ write requesters
// (LSU, spill, DMA). One requester owns the port for a whole transaction
// (one AW command followed by its W beats through wlast). Every accepted AW
// records its owner and response count in an in-order tag FIFO, so that each
// B response is routed back to the requester that issued the command.
//
// Build option: define WR_ARB_FIXED_PRIO_EN for fixed-priority arbitration
// (lowest index wins). Without it, arbitration is round-robin.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req_awvld/req_aw_pkt/req_awrdy per-requester AW channel (pkt packed by index)
//   req_wvld/wdata/wstrb/wlast    per-requester W channel
//   req_wrdy                      per-requester W ready
//   req_bvld/req_brdy             per-requester B handshake
//   req_bresp/req_boram_addr      shared B payload
//   arb_axi_aw*/axi_arb_awrdy     AW towards the AXI interface
//   arb_axi_w*/axi_arb_wrdy       W towards the AXI interface
//   axi_arb_b*/arb_axi_brdy       B from the AXI interface
// -----------------------------------------------------------------------------
module axi_wr_arb #(
    parameter int NREQ      = 2,
    parameter int TAG_DEPTH = 4,
    parameter int AWPKT_W   = 50
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_awvld,
    input  logic [NREQ*AWPKT_W-1:0]   req_aw_pkt,
    output logic [NREQ-1:0]           req_awrdy,
    input  logic [NREQ-1:0]           req_wvld,
    input  logic [NREQ*64-1:0]        req_wdata,
    input  logic [NREQ*8-1:0]         req_wstrb,
    input  logic [NREQ-1:0]           req_wlast,
    output logic [NREQ-1:0]           req_wrdy,
    output logic [NREQ-1:0]           req_bvld,
    output logic [1:0]                req_bresp,
    output logic [11:0]               req_boram_addr,
    input  logic [NREQ-1:0]           req_brdy,
    output logic                      arb_axi_awvld,
    output logic [AWPKT_W-1:0]        arb_axi_aw_pkt,
    input  logic                      axi_arb_awrdy,
    output logic                      arb_axi_wvld,
    output logic [63:0]               arb_axi_wdata,
    output logic [7:0]                arb_axi_wstrb,
    output logic                      arb_axi_wlast,
    input  logic                      axi_arb_wrdy,
    input  logic                      axi_arb_bvld,
    input  logic [1:0]                axi_arb_bresp,
    input  logic [11:0]               axi_arb_oram_addr,
    output logic                      arb_axi_brdy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_WD} state_t;

    state_t          state_reg, state_next;
    logic [GW-1:0]   gnt_reg, gnt_next;
    logic [GW-1:0]   rr_ptr_reg, rr_ptr_next;

    // Tag FIFO: owner and remaining-response count per outstanding AW.
    logic [GW-1:0]   owner_mem [TAG_DEPTH];
    logic [4:0]      rem_mem   [TAG_DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;

    logic            fifo_empty, fifo_full;
    logic [GW-1:0]   head_owner;
    logic [4:0]      head_rem;
    logic            aw_hs, w_hs, b_hs, pop;
    logic            any_req;
    logic [GW-1:0]   winner;
    logic [GW-1:0]   cand_idx;
    int              cand;
    logic [AWPKT_W-1:0] aw_pkt_sel;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CW'(TAG_DEPTH));
    assign head_owner = owner_mem[rd_ptr_reg];
    assign head_rem   = rem_mem[rd_ptr_reg];

    assign aw_pkt_sel = req_aw_pkt[int'(gnt_reg)*AWPKT_W +: AWPKT_W];

    assign aw_hs = (state_reg == ST_AW) && axi_arb_awrdy;
    assign w_hs  = (state_reg == ST_WD) && req_wvld[gnt_reg] && axi_arb_wrdy;
    assign b_hs  = axi_arb_bvld && !fifo_empty && req_brdy[head_owner];
    // The head entry retires on its last expected response.
    assign pop   = b_hs && (head_rem == 5'd1);

    // Search from rr_ptr upwards; iterating downwards lets the lowest
    // offset overwrite, so the first requester at or after rr_ptr wins.
    always_comb begin
        any_req  = 1'b0;
        winner   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = GW'(cand);
            if (req_awvld[cand_idx]) begin
                any_req = 1'b1;
                winner  = cand_idx;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_req && !fifo_full) begin
                    gnt_next   = winner;
                    state_next = ST_AW;
                end
            end
            ST_AW: begin
                if (axi_arb_awrdy) begin
                    state_next = ST_WD;
`ifdef WR_ARB_FIXED_PRIO_EN
                    rr_ptr_next = '0;
`else
                    rr_ptr_next = (gnt_reg == GW'(NREQ - 1)) ? '0 : gnt_reg + 1'b1;
`endif
                end
            end
            ST_WD: begin
                if (w_hs && req_wlast[gnt_reg]) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            gnt_reg    <= '0;
            rr_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            rr_ptr_reg <= rr_ptr_next;
            if (aw_hs) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({aw_hs, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    // A push never targets the head slot while responses are pending there,
    // since pushing requires a non-full FIFO.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            owner_mem[wr_ptr_reg] <= gnt_reg;
            rem_mem[wr_ptr_reg]   <= {1'b0, aw_pkt_sel[15:12]} + 5'd1;
        end
        if (b_hs && !pop) begin
            rem_mem[rd_ptr_reg] <= head_rem - 5'd1;
        end
    end

    // Shared channels: straight pass-through from the registered grant.
    assign arb_axi_awvld  = (state_reg == ST_AW);
    assign arb_axi_aw_pkt = aw_pkt_sel;
    assign arb_axi_wvld   = (state_reg == ST_WD) && req_wvld[gnt_reg];
    assign arb_axi_wdata  = req_wdata[int'(gnt_reg)*64 +: 64];
    assign arb_axi_wstrb  = req_wstrb[int'(gnt_reg)*8 +: 8];
    assign arb_axi_wlast  = req_wlast[gnt_reg];
    // With no tag outstanding a B is held off rather than dropped.
    assign arb_axi_brdy   = !fifo_empty && req_brdy[head_owner];
    assign req_bresp      = axi_arb_bresp;
    assign req_boram_addr = axi_arb_oram_addr;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_awrdy[gi] = aw_hs && (gnt_reg == GW'(gi));
            assign req_wrdy[gi]  = (state_reg == ST_WD) && axi_arb_wrdy && (gnt_reg == GW'(gi));
            assign req_bvld[gi]  = axi_arb_bvld && !fifo_empty && (head_owner == GW'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_axi_wr_arb.sv
`timescale 1ns/1ps
module tb_axi_wr_arb;
    localparam int NREQ = 2, TAG_DEPTH = 4, AWPKT_W = 50, MAXT = 16;

    logic                    clk, rst;
    logic [NREQ-1:0]         req_awvld, req_awrdy, req_wvld, req_wlast, req_wrdy;
    logic [NREQ-1:0]         req_bvld, req_brdy;
    logic [NREQ*AWPKT_W-1:0] req_aw_pkt;
    logic [NREQ*64-1:0]      req_wdata;
    logic [NREQ*8-1:0]       req_wstrb;
    logic [1:0]              req_bresp, axi_arb_bresp;
    logic [11:0]             req_boram_addr, axi_arb_oram_addr;
    logic                    arb_axi_awvld, axi_arb_awrdy, arb_axi_wvld, arb_axi_wlast;
    logic [AWPKT_W-1:0]      arb_axi_aw_pkt;
    logic [63:0]             arb_axi_wdata;
    logic [7:0]              arb_axi_wstrb;
    logic                    axi_arb_wrdy, axi_arb_bvld, arb_axi_brdy;

    axi_wr_arb #(.NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH), .AWPKT_W(AWPKT_W)) dut (
        .clk(clk), .rst(rst),
        .req_awvld(req_awvld), .req_aw_pkt(req_aw_pkt), .req_awrdy(req_awrdy),
        .req_wvld(req_wvld), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_wlast(req_wlast), .req_wrdy(req_wrdy),
        .req_bvld(req_bvld), .req_bresp(req_bresp), .req_boram_addr(req_boram_addr),
        .req_brdy(req_brdy),
        .arb_axi_awvld(arb_axi_awvld), .arb_axi_aw_pkt(arb_axi_aw_pkt),
        .axi_arb_awrdy(axi_arb_awrdy),
        .arb_axi_wvld(arb_axi_wvld), .arb_axi_wdata(arb_axi_wdata),
        .arb_axi_wstrb(arb_axi_wstrb), .arb_axi_wlast(arb_axi_wlast),
        .axi_arb_wrdy(axi_arb_wrdy),
        .axi_arb_bvld(axi_arb_bvld), .axi_arb_bresp(axi_arb_bresp),
        .axi_arb_oram_addr(axi_arb_oram_addr), .arb_axi_brdy(arb_axi_brdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AWPKT_W-1:0] pkt;
        logic [63:0]        base;
        logic [7:0]         strb;
    } txn_t;

    // Requester stimulus state
    txn_t tx [NREQ][MAXT];
    int   ntx [NREQ];
    int   aw_idx [NREQ];
    int   w_txn [NREQ];
    int   w_beat [NREQ];

    // Scoreboard queues filled by the reference model
    logic [AWPKT_W-1:0] exp_aw_q[$];
    int                 exp_aw_own_q[$];
    logic [72:0]        exp_w_q[$];
    int                 exp_w_own_q[$];
    int                 exp_b_own_q[$];
    bit                 exp_b_end_q[$];
    int                 out_tags;
    int                 model_rr;

    // Downstream slave model
    logic [13:0] sb_q[$];
    int aw_rate, w_rate, wv_rate, br_rate;
    bit b_en, b_inject;

    int vectors, miscompares, cyc, aw_cnt;

    function automatic logic [NREQ-1:0] onehot(input int o);
        logic [NREQ-1:0] v;
        v = '0;
        v[o] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AWPKT_W-1:0] make_pkt(input int awlen, input int awnum);
        logic [AWPKT_W-1:0] p;
        p = {$urandom, $urandom};
        p[31:24] = 8'(awlen);
        p[15:12] = 4'(awnum);
        return p;
    endfunction

    task automatic add_txn(input int i, input int awlen, input int awnum);
        tx[i][ntx[i]].pkt  = make_pkt(awlen, awnum);
        tx[i][ntx[i]].base = {$urandom, $urandom};
        tx[i][ntx[i]].strb = 8'($urandom);
        ntx[i]++;
    endtask

    // Reference model: every requester with work left keeps asking, so the
    // grant order is simply a rotation over requesters that still have
    // transactions (or lowest index first with fixed priority).
    task automatic plan();
        int rem [NREQ];
        int nxt [NREQ];
        int g, start, c, nb, an;
        bit any;
        txn_t t;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = ntx[i] - aw_idx[i];
            nxt[i] = aw_idx[i];
        end
        for (int n = 0; n < NREQ * MAXT; n++) begin
            any = 0;
            g = 0;
`ifdef WR_ARB_FIXED_PRIO_EN
            start = 0;
`else
            start = model_rr;
`endif
            for (int k = 0; k < NREQ; k++) begin
                c = (start + k) % NREQ;
                if (!any && rem[c] > 0) begin
                    any = 1;
                    g = c;
                end
            end
            if (any) begin
                t = tx[g][nxt[g]];
                exp_aw_q.push_back(t.pkt);
                exp_aw_own_q.push_back(g);
                nb = int'(t.pkt[31:24]) + 1;
                for (int b = 0; b < nb; b++) begin
                    exp_w_q.push_back({t.base ^ 64'(b), t.strb, (b == nb - 1)});
                    exp_w_own_q.push_back(g);
                end
                an = int'(t.pkt[15:12]);
                for (int r = 0; r <= an; r++) begin
                    exp_b_own_q.push_back(g);
                    exp_b_end_q.push_back(r == an);
                end
                rem[g]--;
                nxt[g]++;
                model_rr = (g + 1) % NREQ;
            end
        end
    endtask

    // One clock of requester and slave behaviour: observe handshakes just
    // before the edge, update drives 1ns after it.
    task automatic step();
        logic [NREQ-1:0] aw_h, w_h;
        logic b_h;
        int nb;
        @(negedge clk);
        aw_h = req_awvld & req_awrdy;
        w_h  = req_wvld & req_wrdy;
        b_h  = axi_arb_bvld & arb_axi_brdy;
        if (arb_axi_awvld && axi_arb_awrdy && !rst) begin
            for (int r = 0; r <= int'(arb_axi_aw_pkt[15:12]); r++)
                sb_q.push_back({2'($urandom), 12'($urandom)});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (b_h) begin
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            axi_arb_bvld = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (aw_h[i]) begin
                w_txn[i]  = aw_idx[i];
                w_beat[i] = 0;
                aw_idx[i]++;
                req_wvld[i] = 1'b0;
            end
            if (w_h[i] && w_txn[i] >= 0) begin
                nb = int'(tx[i][w_txn[i]].pkt[31:24]) + 1;
                w_beat[i]++;
                if (w_beat[i] == nb) w_txn[i] = -1;
            end
            if (aw_idx[i] < ntx[i]) begin
                req_awvld[i] = 1'b1;
                req_aw_pkt[i*AWPKT_W +: AWPKT_W] = tx[i][aw_idx[i]].pkt;
            end else begin
                req_awvld[i] = 1'b0;
                req_aw_pkt[i*AWPKT_W +: AWPKT_W] = '0;
            end
            if (w_txn[i] >= 0) begin
                nb = int'(tx[i][w_txn[i]].pkt[31:24]) + 1;
                if (!req_wvld[i] || w_h[i])
                    req_wvld[i] = ($urandom_range(99) < wv_rate);
                req_wdata[i*64 +: 64] = tx[i][w_txn[i]].base ^ 64'(w_beat[i]);
                req_wstrb[i*8 +: 8]   = tx[i][w_txn[i]].strb;
                req_wlast[i]          = (w_beat[i] == nb - 1);
            end else begin
                req_wvld[i]  = 1'b0;
                req_wlast[i] = 1'b0;
            end
            req_brdy[i] = ($urandom_range(99) < br_rate);
        end
        axi_arb_awrdy = ($urandom_range(99) < aw_rate);
        axi_arb_wrdy  = ($urandom_range(99) < w_rate);
        if (b_inject) begin
            axi_arb_bvld      = 1'b1;
            axi_arb_bresp     = 2'($urandom);
            axi_arb_oram_addr = 12'($urandom);
        end else if (!axi_arb_bvld && b_en && sb_q.size() > 0 && $urandom_range(1) == 1) begin
            axi_arb_bvld      = 1'b1;
            axi_arb_bresp     = sb_q[0][13:12];
            axi_arb_oram_addr = sb_q[0][11:0];
        end
    endtask

    // Monitor: compare every observed handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (arb_axi_awvld && axi_arb_awrdy) begin
                if (exp_aw_q.size() == 0) begin
                    check("aw_unexpected", 1, 0);
                end else begin
                    logic [AWPKT_W-1:0] ep;
                    int eo;
                    ep = exp_aw_q.pop_front();
                    eo = exp_aw_own_q.pop_front();
                    check("aw_pkt", arb_axi_aw_pkt, ep);
                    check("aw_owner", req_awrdy, onehot(eo));
                    check("aw_fifo_room", (out_tags < TAG_DEPTH), 1);
                    $display("AW  cyc=%0d owner=%0d pkt=%0h", cyc, eo, ep);
                    out_tags++;
                    aw_cnt++;
                end
            end
            if (arb_axi_wvld && axi_arb_wrdy) begin
                if (exp_w_q.size() == 0) begin
                    check("w_unexpected", 1, 0);
                end else begin
                    logic [72:0] ew;
                    int eo;
                    ew = exp_w_q.pop_front();
                    eo = exp_w_own_q.pop_front();
                    check("w_beat", {arb_axi_wdata, arb_axi_wstrb, arb_axi_wlast}, ew);
                    check("w_owner", req_wrdy, onehot(eo));
                    $display("W   cyc=%0d owner=%0d data=%0h last=%0b", cyc, eo, arb_axi_wdata, arb_axi_wlast);
                end
            end
            if (axi_arb_bvld && arb_axi_brdy) begin
                if (exp_b_own_q.size() == 0) begin
                    check("b_unexpected", 1, 0);
                end else begin
                    int eo;
                    bit ee;
                    eo = exp_b_own_q.pop_front();
                    ee = exp_b_end_q.pop_front();
                    check("b_owner", req_bvld, onehot(eo));
                    check("b_payload", {req_bresp, req_boram_addr}, {axi_arb_bresp, axi_arb_oram_addr});
                    $display("B   cyc=%0d owner=%0d resp=%0d oram=%0h", cyc, eo, axi_arb_bresp, axi_arb_oram_addr);
                    if (ee) out_tags--;
                end
            end
        end
    end

    task automatic clear_state();
        for (int i = 0; i < NREQ; i++) begin
            ntx[i] = 0; aw_idx[i] = 0; w_txn[i] = -1; w_beat[i] = 0;
        end
        exp_aw_q.delete(); exp_aw_own_q.delete();
        exp_w_q.delete(); exp_w_own_q.delete();
        exp_b_own_q.delete(); exp_b_end_q.delete();
        sb_q.delete();
        out_tags = 0;
        model_rr = 0;
    endtask

    task automatic new_phase();
        for (int i = 0; i < NREQ; i++) begin
            ntx[i] = 0; aw_idx[i] = 0;
        end
    endtask

    task automatic run_until_done(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_aw_q.size() + exp_w_q.size() + exp_b_own_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        check({name, "_completes"}, (n < budget), 1);
    endtask

    initial begin
        int base_cnt, n, m;
        bit seen;
        vectors = 0; miscompares = 0; cyc = 0; aw_cnt = 0;
        rst = 1'b1;
        req_awvld = '0; req_aw_pkt = '0; req_wvld = '0; req_wdata = '0;
        req_wstrb = '0; req_wlast = '0; req_brdy = '0;
        axi_arb_awrdy = 1'b0; axi_arb_wrdy = 1'b0; axi_arb_bvld = 1'b0;
        axi_arb_bresp = '0; axi_arb_oram_addr = '0;
        aw_rate = 100; w_rate = 100; wv_rate = 100; br_rate = 100;
        b_en = 1; b_inject = 0;
        clear_state();
        repeat (3) step();
        #2;
        check("reset_outputs", {req_awrdy, req_wrdy, req_bvld, arb_axi_awvld, arb_axi_wvld, arb_axi_brdy}, '0);
        rst = 1'b0;

        // Reset in the middle of a data phase
        add_txn(0, 3, 0);
        plan();
        w_rate = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            #2;
            seen = (arb_axi_wvld === 1'b1);
        end
        check("reached_wd", seen, 1);
        rst = 1'b1;
        b_inject = 1;
        step();
        #2;
        check("rst_mid_wd", {req_awrdy, req_wrdy, req_bvld, arb_axi_awvld, arb_axi_wvld, arb_axi_brdy}, '0);
        clear_state();
        rst = 1'b0;
        step();
        #2;
        check("b_with_empty_fifo", {req_bvld, arb_axi_brdy}, '0);
        b_inject = 0;
        axi_arb_bvld = 1'b0;
        step();

        // Round-robin order, multi-beat bursts with toggling wrdy, B routing
        new_phase();
        add_txn(0, 1, 2);
        add_txn(1, 3, 0);
        add_txn(0, 0, 1);
        add_txn(1, 2, 0);
        plan();
        aw_rate = 50; w_rate = 50; wv_rate = 70; br_rate = 70;
        run_until_done("rr_directed", 2000);

        // Tag FIFO full: no B returned, only TAG_DEPTH commands may go out
        new_phase();
        for (int k = 0; k < 3; k++) begin
            add_txn(0, k % 2, 0);
            add_txn(1, 1 - k % 2, 0);
        end
        plan();
        aw_rate = 100; w_rate = 100; br_rate = 100; b_en = 0;
        base_cnt = aw_cnt;
        repeat (60) step();
        check("fifo_full_hold", aw_cnt - base_cnt, TAG_DEPTH);
        b_en = 1;
        n = 0;
        while (out_tags == TAG_DEPTH && n < 100) begin
            step();
            n++;
        end
        check("first_pop_seen", (n < 100), 1);
        m = 0;
        while (aw_cnt == base_cnt + TAG_DEPTH && m < 10) begin
            step();
            m++;
        end
        check("grant_after_pop", (m >= 1 && m <= 2), 1);
        run_until_done("fifo_full", 2000);

        // Randomized traffic
        for (int r = 0; r < 6; r++) begin
            new_phase();
            for (int i = 0; i < NREQ; i++) begin
                int cnt;
                cnt = $urandom_range(5);
                for (int k = 0; k < cnt; k++)
                    add_txn(i, $urandom_range(3), $urandom_range(3));
            end
            plan();
            aw_rate = $urandom_range(100, 30);
            w_rate  = $urandom_range(100, 30);
            wv_rate = $urandom_range(100, 30);
            br_rate = $urandom_range(100, 30);
            run_until_done("random", 4000);
        end

        repeat (3) step();
        check("scoreboard_empty", exp_aw_q.size() + exp_w_q.size() + exp_b_own_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
